// File: rtl/str_memory_unit.sv
// Memory-stage store controller: latches STR/STRB and runs a req/ack
// write handshake, stalling upstream until the write is accepted.
module str_memory_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [6:0]  opcode_in,
  input  logic        branch_ref,
  input  logic        branch_in,
  input  logic        sel_stall,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  input  logic        mem_ack,
  output logic [31:0] instr_output,
  output logic        branch_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall_req,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ERR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        byte_q;
  logic        valid_q;

  logic capture;
  logic in_valid;
  logic in_str;
  logic in_byte;
  logic in_misal;
  logic req_on;

  assign capture  = (state_q == IDLE) && !sel_stall;
  assign in_valid = (branch_in == branch_ref);
  assign in_str   = (opcode_in[6:4] == 3'b111) ||
                    (opcode_in[6:3] == 4'b1001);
  assign in_byte  = in_str && opcode_in[0];
  assign in_misal = !in_byte && (store_addr[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    req_on    = 1'b0;
    stall_req = 1'b0;
    mem_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture && in_valid && in_str)
          state_d = in_misal ? ERR : REQ;
      end
      REQ: begin
        req_on    = 1'b1;
        stall_req = 1'b1;
        // ack beats a coincident timeout
        if (mem_ack)
          state_d = IDLE;
        else if (cnt_q == TO_LAST)
          state_d = ERR;
      end
      ERR: begin
        mem_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q != REQ)
        cnt_q <= 8'd0;
      else if (!mem_ack)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_output <= 32'h0;
      branch_value <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
      byte_q       <= 1'b0;
    end else if (capture) begin
      instr_output <= instr_in;
      branch_value <= branch_in;
      valid_q      <= in_valid;
      addr_q       <= store_addr;
      data_q       <= store_data;
      byte_q       <= in_byte;
    end
  end

  assign mem_req = req_on && valid_q;
  assign mem_we  = mem_req;

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (mem_req) begin
      mem_addr = {addr_q[31:2], 2'b00};
      if (byte_q) begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{data_q[7:0]}};
      end else begin
        mem_be    = 4'hF;
        mem_wdata = data_q;
      end
    end
  end

endmodule

// File: tb/tb_str_memory_unit.sv
// Directed bench for str_memory_unit with a 4-cycle timeout.
module tb_str_memory_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [6:0]  opcode_in;
  logic        branch_ref;
  logic        branch_in;
  logic        sel_stall;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        mem_ack;
  logic [31:0] instr_output;
  logic        branch_value;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        stall_req;
  logic        mem_err;

  int n_chk = 0;
  int n_pass = 0;
  int reqs;

  localparam logic [6:0] OP_STR  = 7'b1110000;
  localparam logic [6:0] OP_STRB = 7'b1001001;
  localparam logic [6:0] OP_ALU  = 7'b1100000;

  str_memory_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .opcode_in    (opcode_in),
    .branch_ref   (branch_ref),
    .branch_in    (branch_in),
    .sel_stall    (sel_stall),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .mem_ack      (mem_ack),
    .instr_output (instr_output),
    .branch_value (branch_value),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .stall_req    (stall_req),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [6:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic b);
    instr_in   = ins;
    opcode_in  = op;
    store_addr = a;
    store_data = d;
    branch_in  = b;
    tick();
    opcode_in  = OP_ALU;
    instr_in   = 32'h0;
    branch_in  = branch_ref;
  endtask

  initial begin
    rst = 1'b1;
    instr_in = 32'h0;
    opcode_in = OP_ALU;
    branch_ref = 1'b0;
    branch_in = 1'b0;
    sel_stall = 1'b0;
    store_addr = 32'h0;
    store_data = 32'h0;
    mem_ack = 1'b0;
    tick();
    tick();
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_instr", instr_output, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    rst = 1'b0;
    tick();

    // word store, ack in third REQ cycle
    load(32'hE5801000, OP_STR, 32'h100, 32'hDEADBEEF, 1'b0);
    chk("w_addr", mem_addr, 32'h100);
    chk("w_be", {28'h0, mem_be}, 32'hF);
    chk("w_data", mem_wdata, 32'hDEADBEEF);
    chk("w_we", {31'h0, mem_we}, 32'h1);
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      reqs += int'(mem_req);
      if (i == 2) mem_ack = 1'b1;
      else tick();
    end
    tick();
    mem_ack = 1'b0;
    chk("w_req_cycles", 32'(reqs), 32'd3);
    chk("w_stall_drop", {31'h0, stall_req}, 32'h0);
    chk("w_req_drop", {31'h0, mem_req}, 32'h0);

    // byte store, immediate ack
    load(32'hE5C01003, OP_STRB, 32'h203, 32'h000000A5, 1'b0);
    chk("b_be", {28'h0, mem_be}, 32'h8);
    chk("b_data", mem_wdata, 32'hA5A5A5A5);
    chk("b_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b_done", {31'h0, mem_req}, 32'h0);

    // misaligned word store
    load(32'hE5801002, OP_STR, 32'h102, 32'h12345678, 1'b0);
    chk("mis_req", {31'h0, mem_req}, 32'h0);
    chk("mis_err", {31'h0, mem_err}, 32'h1);
    chk("mis_stall", {31'h0, stall_req}, 32'h0);
    tick();
    chk("mis_err_end", {31'h0, mem_err}, 32'h0);

    // squashed store, then non-store
    load(32'h11112222, OP_STR, 32'h300, 32'h1, 1'b1);
    chk("sq_instr", instr_output, 32'h11112222);
    chk("sq_tag", {31'h0, branch_value}, 32'h1);
    chk("sq_req", {31'h0, mem_req}, 32'h0);
    load(32'h33334444, OP_ALU, 32'h300, 32'h1, 1'b0);
    chk("alu_instr", instr_output, 32'h33334444);
    chk("alu_req", {31'h0, mem_req}, 32'h0);

    // timeout without ack
    load(32'hE5802000, OP_STR, 32'h40, 32'h55, 1'b0);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      reqs += int'(mem_req);
      tick();
    end
    chk("to_req_cycles", 32'(reqs), 32'd4);
    chk("to_err", {31'h0, mem_err}, 32'h1);
    chk("to_req_off", {31'h0, mem_req}, 32'h0);
    tick();
    chk("to_err_end", {31'h0, mem_err}, 32'h0);

    // ack on the last allowed cycle wins
    load(32'hE5802004, OP_STR, 32'h44, 32'h66, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("ack4_req", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("ack4_err", {31'h0, mem_err}, 32'h0);
    chk("ack4_idle", {31'h0, stall_req}, 32'h0);

    // asynchronous reset mid-REQ
    load(32'hE5803000, OP_STR, 32'h80, 32'h77, 1'b0);
    chk("ar_req_pre", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", {31'h0, mem_req}, 32'h0);
    chk("ar_stall", {31'h0, stall_req}, 32'h0);
    chk("ar_instr", instr_output, 32'h0);
    tick();
    rst = 1'b0;
    sel_stall = 1'b1;
    instr_in = 32'hCAFEF00D;
    opcode_in = OP_STR;
    store_addr = 32'h90;
    tick();
    tick();
    chk("hold_instr", instr_output, 32'h0);
    chk("hold_req", {31'h0, mem_req}, 32'h0);
    sel_stall = 1'b0;
    tick();
    chk("rel_instr", instr_output, 32'hCAFEF00D);
    chk("rel_req", {31'h0, mem_req}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
